// File: rtl/fp_minmax_reducer.sv
// Streaming signed floating-point min/max reducer: per-frame extrema values, indices and count.
// Define FP_MINMAX_NAN_CHECK_EN to exclude NaNs from ordering and report them on out_nan.
module fp_minmax_reducer #(
    parameter int DATA_WIDTH = 32,
    parameter int EXP_WIDTH  = 8,
    parameter int IDX_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_last,
    output logic [DATA_WIDTH-1:0] out_max,
    output logic [DATA_WIDTH-1:0] out_min,
    output logic [IDX_WIDTH-1:0]  out_max_idx,
    output logic [IDX_WIDTH-1:0]  out_min_idx,
    output logic [IDX_WIDTH-1:0]  out_count,
    output logic                  out_nan,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int MAG_WIDTH  = DATA_WIDTH - 1;
    localparam int MANT_WIDTH = DATA_WIDTH - 1 - EXP_WIDTH;
    localparam logic [IDX_WIDTH-1:0] IDX_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_e;

    // Sign-magnitude to unsigned-comparable key; both zeros share the +0 key.
    function automatic logic [DATA_WIDTH-1:0] order_key(input logic [DATA_WIDTH-1:0] v);
        logic [MAG_WIDTH-1:0] mag;
        mag = v[MAG_WIDTH-1:0];
        if (mag == '0)
            return {1'b1, {MAG_WIDTH{1'b0}}};
        else if (v[DATA_WIDTH-1])
            return {1'b0, ~mag};
        else
            return {1'b1, mag};
    endfunction

    function automatic logic [IDX_WIDTH-1:0] sat_inc(input logic [IDX_WIDTH-1:0] c);
        return (c == IDX_MAX) ? c : c + IDX_WIDTH'(1);
    endfunction

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] max_q, max_d;
    logic [DATA_WIDTH-1:0] min_q, min_d;
    logic [IDX_WIDTH-1:0]  max_idx_q, max_idx_d;
    logic [IDX_WIDTH-1:0]  min_idx_q, min_idx_d;
    logic [IDX_WIDTH-1:0]  count_q, count_d;

    logic                  accept;
    logic [DATA_WIDTH-1:0] in_key;
    logic                  upd_max;
    logic                  upd_min;

    assign in_ready  = (state_q != S_HOLD);
    assign out_valid = (state_q == S_HOLD);
    assign accept    = in_valid & in_ready;
    assign in_key    = order_key(in_data);
    // Strict comparisons so ties and equal keys keep the earliest element.
    assign upd_max   = in_key > order_key(max_q);
    assign upd_min   = in_key < order_key(min_q);

`ifdef FP_MINMAX_NAN_CHECK_EN
    localparam logic [DATA_WIDTH-1:0] QNAN =
        {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MANT_WIDTH-1){1'b0}}};

    logic nan_q, nan_d;
    logic have_q, have_d;
    logic in_nan;

    assign in_nan  = (in_data[DATA_WIDTH-2 -: EXP_WIDTH] == {EXP_WIDTH{1'b1}}) &&
                     (in_data[MANT_WIDTH-1:0] != '0);
    assign out_nan = nan_q;
`else
    assign out_nan = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        max_d     = max_q;
        min_d     = min_q;
        max_idx_d = max_idx_q;
        min_idx_d = min_idx_q;
        count_d   = count_q;
`ifdef FP_MINMAX_NAN_CHECK_EN
        nan_d     = nan_q;
        have_d    = have_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    count_d   = IDX_WIDTH'(1);
                    max_idx_d = '0;
                    min_idx_d = '0;
                    state_d   = in_last ? S_HOLD : S_ACCUM;
`ifdef FP_MINMAX_NAN_CHECK_EN
                    // A leading NaN parks the canonical qNaN until a real value arrives.
                    nan_d  = in_nan;
                    have_d = !in_nan;
                    max_d  = in_nan ? QNAN : in_data;
                    min_d  = in_nan ? QNAN : in_data;
`else
                    max_d  = in_data;
                    min_d  = in_data;
`endif
                end
            end
            S_ACCUM: begin
                if (accept) begin
                    count_d = sat_inc(count_q);
                    state_d = in_last ? S_HOLD : S_ACCUM;
`ifdef FP_MINMAX_NAN_CHECK_EN
                    if (in_nan) begin
                        nan_d = 1'b1;
                    end else if (!have_q) begin
                        have_d    = 1'b1;
                        max_d     = in_data;
                        min_d     = in_data;
                        max_idx_d = count_q;
                        min_idx_d = count_q;
                    end else begin
                        if (upd_max) begin
                            max_d     = in_data;
                            max_idx_d = count_q;
                        end
                        if (upd_min) begin
                            min_d     = in_data;
                            min_idx_d = count_q;
                        end
                    end
`else
                    if (upd_max) begin
                        max_d     = in_data;
                        max_idx_d = count_q;
                    end
                    if (upd_min) begin
                        min_d     = in_data;
                        min_idx_d = count_q;
                    end
`endif
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                    count_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            max_q     <= '0;
            min_q     <= '0;
            max_idx_q <= '0;
            min_idx_q <= '0;
            count_q   <= '0;
`ifdef FP_MINMAX_NAN_CHECK_EN
            nan_q     <= 1'b0;
            have_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            max_q     <= max_d;
            min_q     <= min_d;
            max_idx_q <= max_idx_d;
            min_idx_q <= min_idx_d;
            count_q   <= count_d;
`ifdef FP_MINMAX_NAN_CHECK_EN
            nan_q     <= nan_d;
            have_q    <= have_d;
`endif
        end
    end

    assign out_max     = max_q;
    assign out_min     = min_q;
    assign out_max_idx = max_idx_q;
    assign out_min_idx = min_idx_q;
    assign out_count   = count_q;

endmodule

// File: tb/tb_fp_minmax_reducer.sv
// Bench for fp_minmax_reducer: directed scenarios plus random frames against an ordering model.
module tb_fp_minmax_reducer;

    localparam int DW  = 32;
    localparam int EW  = 8;
    localparam int IW  = 16;
    localparam int SIW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid, in_last, in_ready;
    logic [DW-1:0] out_max, out_min;
    logic [IW-1:0] out_max_idx, out_min_idx, out_count;
    logic          out_nan, out_valid, out_ready;

    logic [DW-1:0]  s_in_data;
    logic           s_in_valid, s_in_last, s_in_ready;
    logic [DW-1:0]  s_out_max, s_out_min;
    logic [SIW-1:0] s_out_max_idx, s_out_min_idx, s_out_count;
    logic           s_out_nan, s_out_valid, s_out_ready;

    fp_minmax_reducer #(.DATA_WIDTH(DW), .EXP_WIDTH(EW), .IDX_WIDTH(IW)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .out_max(out_max), .out_min(out_min), .out_max_idx(out_max_idx),
        .out_min_idx(out_min_idx), .out_count(out_count), .out_nan(out_nan),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    fp_minmax_reducer #(.DATA_WIDTH(DW), .EXP_WIDTH(EW), .IDX_WIDTH(SIW)) dut_sat (
        .clk(clk), .rst(rst), .in_data(s_in_data), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_last(s_in_last), .out_max(s_out_max), .out_min(s_out_min), .out_max_idx(s_out_max_idx),
        .out_min_idx(s_out_min_idx), .out_count(s_out_count), .out_nan(s_out_nan),
        .out_valid(s_out_valid), .out_ready(s_out_ready)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] frame_q[$];
    logic [DW-1:0] e_max, e_min;
    logic [IW-1:0] e_maxi, e_mini, e_cnt;
    logic          e_nan;

    // Real-number ordering of the bit pattern as a signed integer; -0 and +0 both give 0.
    function automatic longint ord_val(input logic [DW-1:0] d);
        longint mag;
        mag = longint'(d[DW-2:0]);
        return d[DW-1] ? -mag : mag;
    endfunction

    function automatic bit is_nan(input logic [DW-1:0] d);
        return (d[30:23] == 8'hFF) && (d[22:0] != 23'd0);
    endfunction

    // Reference result of frame_q; indices and count clip at sat_max.
    task automatic model(input int sat_max);
        longint vmax, vmin, v;
        bit     have;
        int     idx, n;
        have = 0; vmax = 0; vmin = 0;
        e_nan = 1'b0; e_max = '0; e_min = '0; e_maxi = '0; e_mini = '0;
        for (int i = 0; i < frame_q.size(); i++) begin
            idx = (i > sat_max) ? sat_max : i;
`ifdef FP_MINMAX_NAN_CHECK_EN
            if (is_nan(frame_q[i])) begin
                e_nan = 1'b1;
                continue;
            end
`endif
            v = ord_val(frame_q[i]);
            if (!have) begin
                have = 1; vmax = v; vmin = v;
                e_max = frame_q[i]; e_min = frame_q[i];
                e_maxi = IW'(idx); e_mini = IW'(idx);
            end else begin
                if (v > vmax) begin vmax = v; e_max = frame_q[i]; e_maxi = IW'(idx); end
                if (v < vmin) begin vmin = v; e_min = frame_q[i]; e_mini = IW'(idx); end
            end
        end
        if (!have) begin
            e_max = 32'h7FC00000; e_min = 32'h7FC00000; e_maxi = '0; e_mini = '0;
        end
        n = frame_q.size();
        e_cnt = IW'((n > sat_max) ? sat_max : n);
    endtask

    function automatic logic [DW-1:0] pick_elem();
        case ($urandom_range(0, 9))
            0: return 32'h00000000;
            1: return 32'h80000000;
            2: return 32'h7F800000;
            3: return 32'hFF800000;
            4: return 32'h7FC00000;
            5: return 32'h3F800000;
            6: return 32'hBF800000;
            default: return $urandom;
        endcase
    endfunction

    // Offer one element and wait for it to be taken; leaves time at posedge+1.
    task automatic push(input logic [DW-1:0] d, input logic last);
        int guard;
        guard = 0;
        in_data = d; in_valid = 1'b1; in_last = last;
        while (in_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        if (guard >= 50) begin
            checks++; failures++;
            $display("FAIL push_timeout in_ready=%b required=1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic drive_frame(input int max_gap);
        int gap;
        for (int i = 0; i < frame_q.size(); i++) begin
            gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
            for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
            push(frame_q[i], (i == frame_q.size() - 1));
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
        s_in_valid = 1'b0; s_in_last = 1'b0; s_in_data = '0; s_out_ready = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_max !== 32'h0 || out_min !== 32'h0) begin failures++; $display("FAIL reset_extrema got=%h/%h exp=0/0", out_max, out_min); end
        checks++; if (out_max_idx !== '0 || out_min_idx !== '0 || out_count !== '0) begin failures++; $display("FAIL reset_idx got=%0d/%0d/%0d exp=0", out_max_idx, out_min_idx, out_count); end
        checks++; if (out_nan !== 1'b0) begin failures++; $display("FAIL reset_nan got=%b exp=0", out_nan); end
        checks++; if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0) begin failures++; $display("FAIL reset_sat got=%b/%b exp=1/0", s_in_ready, s_out_valid); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        frame_q = '{32'h40400000, 32'hBF800000, 32'h40200000};
        model(65535);
        drive_frame(0);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_latency out_valid=%b exp=1", out_valid); end
        checks++; if (out_max !== 32'h40400000 || out_max_idx !== 16'd0) begin failures++; $display("FAIL basic_max got=%h@%0d exp=40400000@0", out_max, out_max_idx); end
        checks++; if (out_min !== 32'hBF800000 || out_min_idx !== 16'd1) begin failures++; $display("FAIL basic_min got=%h@%0d exp=bf800000@1", out_min, out_min_idx); end
        checks++; if (out_count !== e_cnt) begin failures++; $display("FAIL basic_count got=%0d exp=%0d", out_count, e_cnt); end
        release_result();
    endtask

    task automatic test_signed_zero();
        frame_q = '{32'h80000000, 32'h00000000, 32'h80000000};
        model(65535);
        drive_frame(1);
        checks++; if (out_max !== 32'h80000000 || out_max_idx !== 16'd0) begin failures++; $display("FAIL zero_max got=%h@%0d exp=80000000@0", out_max, out_max_idx); end
        checks++; if (out_min !== 32'h80000000 || out_min_idx !== 16'd0) begin failures++; $display("FAIL zero_min got=%h@%0d exp=80000000@0", out_min, out_min_idx); end
        checks++; if (out_count !== 16'd3) begin failures++; $display("FAIL zero_count got=%0d exp=3", out_count); end
        release_result();
    endtask

    task automatic test_inf_backpressure();
        frame_q = '{32'h7F800000, 32'hFF800000};
        model(65535);
        drive_frame(0);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_max !== e_max || out_min !== e_min ||
                out_max_idx !== e_maxi || out_min_idx !== e_mini || out_count !== e_cnt) begin
                failures++;
                $display("FAIL inf_hold cyc=%0d got v=%b r=%b %h/%h exp v=1 r=0 %h/%h", c, out_valid, in_ready, out_max, out_min, e_max, e_min);
            end
            @(posedge clk); #1;
        end
        release_result();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL inf_release got v=%b r=%b exp v=0 r=1", out_valid, in_ready); end
    endtask

    task automatic test_nan();
        frame_q = '{32'h7FC00000, 32'h3F800000};
        model(65535);
        drive_frame(0);
`ifdef FP_MINMAX_NAN_CHECK_EN
        checks++; if (out_max !== 32'h3F800000 || out_min !== 32'h3F800000 || out_max_idx !== 16'd1 || out_min_idx !== 16'd1) begin failures++; $display("FAIL nan_extrema got=%h@%0d/%h@%0d exp=3f800000@1 both", out_max, out_max_idx, out_min, out_min_idx); end
        checks++; if (out_nan !== 1'b1) begin failures++; $display("FAIL nan_flag got=%b exp=1", out_nan); end
`else
        checks++; if (out_max !== 32'h7FC00000 || out_max_idx !== 16'd0 || out_min !== 32'h3F800000 || out_min_idx !== 16'd1) begin failures++; $display("FAIL nan_extrema got=%h@%0d/%h@%0d exp=7fc00000@0/3f800000@1", out_max, out_max_idx, out_min, out_min_idx); end
        checks++; if (out_nan !== 1'b0) begin failures++; $display("FAIL nan_flag got=%b exp=0", out_nan); end
`endif
        checks++; if (out_count !== 16'd2) begin failures++; $display("FAIL nan_count got=%0d exp=2", out_count); end
        release_result();
    endtask

    task automatic test_reset_midframe();
        push(32'h41000000, 1'b0);
        push(32'hC1000000, 1'b0);
        #2 rst = 1'b1;
        #1;
        checks++; if (out_count !== '0 || out_max !== '0 || out_min !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL midreset_async got cnt=%0d max=%h min=%h v=%b r=%b exp all 0, r=1", out_count, out_max, out_min, out_valid, in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        frame_q = '{32'h40000000};
        model(65535);
        drive_frame(0);
        checks++; if (out_valid !== 1'b1 || out_max !== 32'h40000000 || out_min !== 32'h40000000 || out_max_idx !== '0 || out_min_idx !== '0 || out_count !== 16'd1) begin failures++; $display("FAIL midreset_frame got v=%b %h/%h cnt=%0d exp v=1 40000000 cnt=1", out_valid, out_max, out_min, out_count); end
        release_result();
    endtask

    task automatic test_saturation();
        int guard;
        frame_q = {};
        for (int i = 0; i < 20; i++) frame_q.push_back((i == 19) ? 32'h40A00000 : 32'h3F800000);
        model(15);
        for (int i = 0; i < 20; i++) begin
            s_in_data = frame_q[i]; s_in_valid = 1'b1; s_in_last = (i == 19);
            guard = 0;
            while (s_in_ready !== 1'b1 && guard < 50) begin @(posedge clk); #1; guard++; end
            @(posedge clk); #1;
        end
        s_in_valid = 1'b0; s_in_last = 1'b0;
        checks++; if (s_out_valid !== 1'b1) begin failures++; $display("FAIL sat_valid got=%b exp=1", s_out_valid); end
        checks++; if (s_out_count !== 4'd15 || s_out_count !== e_cnt[SIW-1:0]) begin failures++; $display("FAIL sat_count got=%0d exp=15", s_out_count); end
        checks++; if (s_out_max !== 32'h40A00000 || s_out_max_idx !== 4'd15) begin failures++; $display("FAIL sat_max got=%h@%0d exp=40a00000@15", s_out_max, s_out_max_idx); end
        checks++; if (s_out_min !== e_min || s_out_min_idx !== 4'd0) begin failures++; $display("FAIL sat_min got=%h@%0d exp=%h@0", s_out_min, s_out_min_idx, e_min); end
        s_out_ready = 1'b1;
        @(posedge clk); #1;
        s_out_ready = 1'b0;
        checks++; if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1) begin failures++; $display("FAIL sat_release got v=%b r=%b exp v=0 r=1", s_out_valid, s_in_ready); end
    endtask

    task automatic test_random();
        int len, hold;
        for (int f = 0; f < 40; f++) begin
            frame_q = {};
            len = $urandom_range(1, 9);
            for (int i = 0; i < len; i++) frame_q.push_back(pick_elem());
            model(65535);
            drive_frame(2);
            checks++;
            if (out_valid !== 1'b1 || out_max !== e_max || out_min !== e_min || out_max_idx !== e_maxi ||
                out_min_idx !== e_mini || out_count !== e_cnt || out_nan !== e_nan) begin
                failures++;
                $display("FAIL rand_frame f=%0d got v=%b max=%h@%0d min=%h@%0d cnt=%0d nan=%b exp v=1 max=%h@%0d min=%h@%0d cnt=%0d nan=%b",
                         f, out_valid, out_max, out_max_idx, out_min, out_min_idx, out_count, out_nan,
                         e_max, e_maxi, e_min, e_mini, e_cnt, e_nan);
            end
            hold = $urandom_range(0, 3);
            for (int c = 0; c < hold; c++) begin
                @(posedge clk); #1;
                checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_max !== e_max || out_min !== e_min) begin failures++; $display("FAIL rand_hold f=%0d got v=%b r=%b %h/%h exp v=1 r=0 %h/%h", f, out_valid, in_ready, out_max, out_min, e_max, e_min); end
            end
            release_result();
        end
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 3; f++) begin
            frame_q = '{pick_elem(), pick_elem()};
            model(65535);
            drive_frame(0);
            checks++; if (out_valid !== 1'b1 || out_max !== e_max || out_min !== e_min || out_max_idx !== e_maxi || out_min_idx !== e_mini) begin failures++; $display("FAIL b2b f=%0d got %h@%0d/%h@%0d exp %h@%0d/%h@%0d", f, out_max, out_max_idx, out_min, out_min_idx, e_max, e_maxi, e_min, e_mini); end
            release_result();
            checks++; if (in_ready !== 1'b1 || out_count !== '0) begin failures++; $display("FAIL b2b_idle f=%0d got r=%b cnt=%0d exp r=1 cnt=0", f, in_ready, out_count); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed_zero();
        test_inf_backpressure();
        test_nan();
        test_reset_midframe();
        test_saturation();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog sim_time=%0t limit=400000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
